wb_host_master: RTL
===================

Name: wb_host_master

Overview:
- Wishbone B4 classic initiator. Converts a valid/ready command stream into single bus cycles; returns each result on a valid/ready response stream.
- It is the opposite end of the user-area Wishbone slave port. It lets on-chip logic (LA- or IO-driven test sequencers) drive a wbs_* responder exactly as the management SoC does.
- One outstanding transaction at a time; no bursts, no pipelining.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255, maximum wait for ack/err before forced termination. Used only with the optional feature.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  AW  byte address
- cmd_dat_i  in  DW  write data
- cmd_sel_i  in  DW/8  byte enables
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_dat_o  out  DW  read data; 0 for writes
- rsp_err_o  out  1  bus error or timeout
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  DW/8  Wishbone byte select
- wbm_adr_o  out  AW  Wishbone address
- wbm_dat_o  out  DW  Wishbone write data
- wbm_dat_i  in  DW  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_err_i  in  1  Wishbone error

Behaviour:
- Clocking and reset: one clock, wb_clk_i. wb_rst_ni is asynchronous active-low. While it is low, all outputs are 0 and the FSM is IDLE, including cmd_ready_o. All outputs are registered except cmd_ready_o, which is decoded from state.
- FSM states: IDLE, BUS, RESP.
  - IDLE: cmd_ready_o=1. On a rising edge with cmd_valid_i=1, latch we/adr/dat/sel into wbm_* and set cyc=stb=1. Next state BUS.
  - BUS: cmd_ready_o=0. wbm_* stay stable. On an edge with wbm_ack_i or wbm_err_i high, clear cyc/stb on that edge. On the same edge capture rsp_dat_o (wbm_dat_i if read, else 0), set rsp_err_o=wbm_err_i and rsp_valid_o=1. Next state RESP.
  - RESP: cmd_ready_o=0, cyc=stb=0. On an edge with rsp_ready_i=1, clear rsp_valid_o. Next state IDLE. rsp_dat_o and rsp_err_o hold until the next response is loaded.
- Latency: accept at edge N → cyc/stb high after N. A zero-wait ack sampled at N+1 → rsp_valid_o high after N+1. Minimum command-to-command spacing is 3 cycles.
- Simultaneous ack and err: err wins (rsp_err_o=1, rsp_dat_o=0).
- ack/err seen outside BUS: ignored.
- cmd_valid_i outside IDLE: ignored; the command is held by the upstream side per valid/ready rules.
- wbm_sel_o passes cmd_sel_i through unchanged; sel=0 is still issued as a cycle.
- Reset asserted mid-cycle: cyc/stb drop immediately (asynchronously); any pending response is discarded.
- After the response handshake, wbm_adr_o, wbm_dat_o, wbm_we_o and wbm_sel_o hold their last values; only cyc/stb are guaranteed 0.

Optional Feature:
- Macro: WB_HOST_TIMEOUT_EN.
- When defined: a counter clears on entry to BUS and increments each BUS cycle. If it reaches TIMEOUT_CYCLES with no ack/err, then on that edge cyc/stb drop, rsp_err_o=1, rsp_dat_o=0, and the next state is RESP. A same-edge ack/err takes priority over the timeout.
- When undefined: no counter logic exists; BUS waits indefinitely.

Decomposition:
- Package wb_host_pkg: state enum typedef (IDLE/BUS/RESP), default AW/DW constants, and a timeout-width constant equal to $clog2(TIMEOUT_CYCLES+1).
- One sub-module, wb_host_timeout. Inputs: clear and count-enable. Output: expired. Instantiated only under WB_HOST_TIMEOUT_EN.

Test Plan:
- Write adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF; slave acks after 2 wait states → bus shows we=1 with those values. rsp_valid_o=1 with rsp_err_o=0 and rsp_dat_o=0. cmd_ready_o low from acceptance until the response handshake.
- Read adr=0x3000_0008; slave returns 0xDEAD_BEEF with zero-wait ack → rsp_valid_o one cycle after ack, rsp_dat_o=0xDEAD_BEEF.
- Slave asserts ack and err on the same cycle → rsp_err_o=1, rsp_dat_o=0, cyc/stb low the next cycle.
- Read with rsp_ready_i held low for 5 cycles → rsp_valid_o, rsp_dat_o and rsp_err_o stable for all 5 cycles. A cmd_valid_i presented meanwhile is not accepted until after the rsp handshake.
- With WB_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never acks → cyc drops after 8 BUS cycles, rsp_err_o=1. A subsequent normal read succeeds.
- wb_rst_ni pulsed low mid-BUS (not clock-aligned) → cyc/stb/rsp_valid_o go 0 immediately. After release, cmd_ready_o=1 and no stale response appears.

Source files
------------

// File: rtl/wb_host_pkg.sv
// Shared types and defaults for the Wishbone host initiator.
package wb_host_pkg;

    localparam int unsigned DEFAULT_AW             = 32;
    localparam int unsigned DEFAULT_DW             = 32;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned TIMEOUT_W              = $clog2(DEFAULT_TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog: counts BUS cycles and flags the edge on which the limit is reached.
module wb_host_timeout
    import wb_host_pkg::*;
#(
    parameter int unsigned CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned W      = TIMEOUT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count;

    // expired marks the CYCLES-th counted edge, so the bus is held exactly CYCLES cycles
    assign expired = count_en && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/wb_host_master.sv
// Wishbone B4 classic single-cycle initiator driven by a valid/ready command stream.
// Optional bus timeout enabled by defining WB_HOST_TIMEOUT_EN.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int unsigned AW             = DEFAULT_AW,
    parameter int unsigned DW             = DEFAULT_DW,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,

    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,

    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,

    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i
);

    if (DW % 8 != 0) begin : g_dw_check
        $error("wb_host_master: DW must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("wb_host_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    logic   timed_out;

    // Gated with reset so ready is low while reset is held, not just in IDLE.
    assign cmd_ready_o = (state == IDLE) && wb_rst_ni;

`ifdef WB_HOST_TIMEOUT_EN
    wb_host_timeout #(
        .CYCLES (TIMEOUT_CYCLES),
        .W      ($clog2(TIMEOUT_CYCLES + 1))
    ) u_timeout (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .clear    (state != BUS),
        .count_en (state == BUS),
        .expired  (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wbm_we_o  <= cmd_we_i;
                        wbm_adr_o <= cmd_adr_i;
                        wbm_dat_o <= cmd_dat_i;
                        wbm_sel_o <= cmd_sel_i;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // ack/err outrank the timeout; err outranks ack and zeroes the data
                    if (wbm_ack_i || wbm_err_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= wbm_err_i;
                        rsp_dat_o   <= (wbm_err_i || wbm_we_o) ? '0 : wbm_dat_i;
                        state       <= RESP;
                    end else if (timed_out) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_dat_o   <= '0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    wbm_cyc_o   <= 1'b0;
                    wbm_stb_o   <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
